router_port_arbiter: RTL and testbench
======================================

ROUTER_PORT_ARBITER -- requirements
Module: router_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 16, meaning the number of input ports competing for one router output port.
REQ-002 The block SHALL have parameter TIMEOUT, default 1024, meaning the maximum number of cycles a single grant may be held.
REQ-003 The block SHALL have port clock, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning the reset; it is asynchronous and active-high.
REQ-005 The block SHALL have port req, input, NUM_PORTS, meaning that input port i has a packet for this output; it is held high through the packet's last frame cycle.
REQ-006 The block SHALL have port grant, output, NUM_PORTS, meaning the registered one-hot grant.
REQ-007 The block SHALL have port grant_valid, output, 1, meaning that grant is non-zero.
REQ-008 The block SHALL have port grant_id, output, clog2(NUM_PORTS), meaning the index of the granted port; it is 0 when grant_valid is low.
REQ-009 The block SHALL have port busy, output, NUM_PORTS, meaning req[i] is high and port i is not granted.
REQ-010 The block SHALL have port timeout_err, output, 1, meaning a one-cycle pulse on a forced release.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, GRANT and RELEASE.
REQ-012 In IDLE with any eligible req bit high, the block SHALL pick one requester by round-robin and enter GRANT; grant, grant_valid and grant_id SHALL assert on the next rising edge (1-cycle latency).
REQ-013 Round-robin SHALL search from index (last_id+1) mod NUM_PORTS upward with wrap-around, where last_id is the most recently granted index.
REQ-014 last_id SHALL update when a grant is issued.
REQ-015 A port is eligible when req[i] is high and lockout[i] is low.
REQ-016 In IDLE with no eligible req, the block SHALL stay in IDLE with grant all-zero.
REQ-017 In GRANT, grant SHALL remain constant while req[grant_id] stays high; no preemption by other requesters.
REQ-018 In GRANT, when req[grant_id] is low, the next state SHALL be RELEASE, with grant cleared on that same edge.
REQ-019 RELEASE SHALL last exactly one cycle with grant all-zero, then the FSM SHALL go to IDLE, giving a minimum 1-cycle bus gap between packets.
REQ-020 The hold counter SHALL clear on entry to GRANT and increment every GRANT cycle.
REQ-021 If the hold counter equals TIMEOUT-1 while req[grant_id] is still high, the block SHALL go to RELEASE, pulse timeout_err for 1 cycle and set lockout[grant_id].
REQ-022 lockout[i] SHALL clear in any cycle in which req[i] is low.
REQ-023 A locked-out port SHALL show busy high while its req stays high.
REQ-024 If req[grant_id] falls in the same cycle the counter reaches TIMEOUT-1, the block SHALL perform a normal release with no timeout_err and no lockout.
REQ-025 busy SHALL be computed from the current req and the registered grant: busy = req & ~grant.
REQ-026 A req bit that rises and falls while the port is not granted SHALL never be granted; no request is latched.
REQ-027 The hold counter SHALL be clog2(TIMEOUT) bits wide and SHALL saturate rather than wrap.

Reset
REQ-028 While reset is high, the block SHALL hold: FSM = IDLE, grant = 0, grant_valid = 0, grant_id = 0, timeout_err = 0, lockout = 0, hold counter = 0, last_id = NUM_PORTS-1 (so port 0 has first priority).
REQ-029 While reset is high, busy SHALL equal req.
REQ-030 Reset asserted mid-GRANT SHALL drop grant asynchronously, with no RELEASE cycle and no timeout_err.
REQ-031 The first arbitration after reset SHALL occur on the first rising edge after reset deasserts.

Structure
REQ-032 Package router_arb_pkg SHALL hold the NUM_PORTS default, the PORT_ID_W = clog2(NUM_PORTS) constant and the arb_state_t enum (IDLE, GRANT, RELEASE).
REQ-033 Sub-module rr_pick SHALL be purely combinational: inputs req_masked and last_id, outputs found and pick_id. It is used once.
REQ-034 All outputs except busy SHALL be registered.

Verification
REQ-035 Directed test: reset released, req = 0x0001 held 5 cycles then dropped -> grant = 0x0001 one cycle after req rises; grant held 5 cycles; 1 RELEASE cycle with grant = 0; busy = 0 throughout.
REQ-036 Directed test: req = 0xFFFF held continuously, each holder drops its req for 1 cycle after a 3-cycle packet -> grant order 0, 1, 2, ..., 15, 0; every gap exactly 1 cycle; busy = 0xFFFF & ~grant.
REQ-037 Directed test: last_id = 14, then req = 0x4001 -> port 15 not requesting, so port 0 is granted (wrap-around), not port 14.
REQ-038 Directed test: TIMEOUT = 8, req[3] held high forever -> grant[3] high for 8 cycles, timeout_err pulses once, port 3 not re-granted and busy[3] = 1 until req[3] drops for at least 1 cycle.
REQ-039 Directed test: TIMEOUT = 8, req[3] drops on the 8th grant cycle -> normal release, timeout_err = 0, lockout[3] = 0.
REQ-040 Directed test: reset pulsed during GRANT of port 7 with req = 0x0081 -> grant = 0 immediately; after reset, port 0 is granted first.

Source files
------------

// File: rtl/router_port_arbiter_pkg.sv
// router_arb_pkg
// Shared constants and types for the router output-port arbiter.
//   NUM_PORTS_DEF : default number of input ports competing for one output
//   PORT_ID_W     : width of a port index for the default port count
//   arb_state_t   : arbiter FSM states (IDLE, GRANT, RELEASE)
package router_arb_pkg;

  localparam int NUM_PORTS_DEF = 16;
  localparam int PORT_ID_W     = $clog2(NUM_PORTS_DEF);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/router_port_arbiter_if.sv
// router_port_arbiter_if
// Bundles the request/grant signals between the input ports and the arbiter
// of one router output port.
//   req         : per-port request, held high through the packet's last frame
//   grant       : registered one-hot grant
//   grant_valid : grant is non-zero
//   grant_id    : index of the granted port, 0 when nothing is granted
//   busy        : port is requesting but does not hold the grant
//   timeout_err : one-cycle pulse when a grant is forcibly released
// Modports:
//   master : the requesting side (drives req, observes the rest)
//   slave  : the arbiter side (observes req, drives the rest)
interface router_port_arbiter_if
  import router_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ID_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] grant;
  logic                 grant_valid;
  logic [ID_W-1:0]      grant_id;
  logic [NUM_PORTS-1:0] busy;
  logic                 timeout_err;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  busy,
    input  timeout_err
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output grant_id,
    output busy,
    output timeout_err
  );

endinterface

// File: rtl/router_port_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin picker. Searches req_masked starting just above
// last_id, wrapping around, and returns the first set index.
//   req_masked : eligible requesters (req with locked-out ports removed)
//   last_id    : most recently granted port index
//   found      : at least one eligible requester exists
//   pick_id    : chosen port index (0 when found is low)
module rr_pick
  import router_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ID_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req_masked,
  input  logic [ID_W-1:0]      last_id,
  output logic                 found,
  output logic [ID_W-1:0]      pick_id
);

  // Walk the ports in priority order last_id+1, last_id+2, ... wrapping back
  // to last_id itself as the lowest priority; the first eligible one wins.
  always_comb begin
    int idx_full;
    logic [ID_W-1:0] idx;
    found    = 1'b0;
    pick_id  = '0;
    idx_full = 0;
    idx      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx_full = (int'(last_id) + k) % NUM_PORTS;
      idx      = ID_W'(idx_full);
      if (!found && req_masked[idx]) begin
        found   = 1'b1;
        pick_id = idx;
      end
    end
  end

endmodule

// File: rtl/router_port_arbiter.sv
// router_port_arbiter
// Round-robin arbiter granting one router output port to one of NUM_PORTS
// input ports at a time. A grant is held for the whole packet (while the
// holder keeps req high), followed by a one-cycle RELEASE gap. A holder that
// keeps req high for TIMEOUT cycles is forcibly released, flagged with
// timeout_err, and locked out until it drops req for at least one cycle.
// Ports:
//   clock : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : router_port_arbiter_if.slave (req in; grant, grant_valid,
//           grant_id, busy, timeout_err out)
module router_port_arbiter
  import router_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int TIMEOUT   = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  router_port_arbiter_if.slave  bus
);

  // For the default port count ID_W equals PORT_ID_W.
  localparam int ID_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CNT_W-1:0]     HOLD_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]     HOLD_SAT   = '1;
  localparam logic [NUM_PORTS-1:0] GRANT_LSB  = NUM_PORTS'(1);
  localparam logic [ID_W-1:0]      LAST_INIT  = ID_W'(NUM_PORTS - 1);

  arb_state_t           state_q, state_n;
  logic [NUM_PORTS-1:0] grant_q, grant_n;
  logic                 valid_q, valid_n;
  logic [ID_W-1:0]      id_q, id_n;
  logic                 tout_q, tout_n;
  logic [NUM_PORTS-1:0] lockout_q, lockout_n;
  logic [CNT_W-1:0]     hold_q, hold_n;
  logic [ID_W-1:0]      last_id_q, last_id_n;

  logic [NUM_PORTS-1:0] eligible;
  logic                 found;
  logic [ID_W-1:0]      pick_id;

  assign eligible = bus.req & ~lockout_q;

  rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .ID_W      (ID_W)
  ) u_rr_pick (
    .req_masked (eligible),
    .last_id    (last_id_q),
    .found      (found),
    .pick_id    (pick_id)
  );

  // Next-state and next-output logic. RELEASE is the one-cycle bus gap: the
  // grant is already zero during it, and the arbitration that ends it is the
  // same one IDLE performs, so back-to-back packets see exactly one idle
  // cycle. Lockout bits drop whenever their request is low.
  always_comb begin
    state_n   = state_q;
    grant_n   = grant_q;
    valid_n   = valid_q;
    id_n      = id_q;
    tout_n    = 1'b0;
    hold_n    = hold_q;
    last_id_n = last_id_q;
    lockout_n = lockout_q & bus.req;

    unique case (state_q)
      IDLE, RELEASE: begin
        state_n = IDLE;
        grant_n = '0;
        valid_n = 1'b0;
        id_n    = '0;
        if (found) begin
          state_n   = GRANT;
          grant_n   = GRANT_LSB << pick_id;
          valid_n   = 1'b1;
          id_n      = pick_id;
          hold_n    = '0;
          last_id_n = pick_id;
        end
      end

      GRANT: begin
        // A holder dropping req on the limit cycle is a normal release, so
        // the req test comes before the hold-limit test.
        if (!bus.req[id_q]) begin
          state_n = RELEASE;
          grant_n = '0;
          valid_n = 1'b0;
          id_n    = '0;
        end else if (hold_q == HOLD_LIMIT) begin
          state_n         = RELEASE;
          grant_n         = '0;
          valid_n         = 1'b0;
          id_n            = '0;
          tout_n          = 1'b1;
          lockout_n[id_q] = 1'b1;
        end else if (hold_q != HOLD_SAT) begin
          hold_n = hold_q + CNT_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
        grant_n = '0;
        valid_n = 1'b0;
        id_n    = '0;
      end
    endcase
  end

  // State and output registers. last_id resets to the top port so port 0
  // is first in line after reset; reset drops the grant immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      tout_q    <= 1'b0;
      lockout_q <= '0;
      hold_q    <= '0;
      last_id_q <= LAST_INIT;
    end else begin
      state_q   <= state_n;
      grant_q   <= grant_n;
      valid_q   <= valid_n;
      id_q      <= id_n;
      tout_q    <= tout_n;
      lockout_q <= lockout_n;
      hold_q    <= hold_n;
      last_id_q <= last_id_n;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_id    = id_q;
  assign bus.timeout_err = tout_q;
  // busy follows req combinationally so it equals req while reset is held.
  assign bus.busy        = bus.req & ~grant_q;

endmodule

// File: tb/tb_router_port_arbiter.sv
// tb_router_port_arbiter
// Self-checking bench for router_port_arbiter (16 ports, TIMEOUT = 8).
// A packet-level reference model tracks who holds the output, how many
// cycles it has held it, the last winner and the locked-out ports; every
// cycle the DUT outputs are compared against it. Directed scenarios are
// followed by a randomized request phase.
module tb_router_port_arbiter;
  import router_arb_pkg::*;

  localparam int N       = 16;
  localparam int TIMEOUT = 8;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  router_port_arbiter_if #(.NUM_PORTS(N)) bus ();

  router_port_arbiter #(
    .NUM_PORTS (N),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model state
  logic         mActive;
  logic [3:0]   mHolder;
  logic [3:0]   mLast;
  int           mHeld;
  logic [N-1:0] mLock;
  logic         mTimeout;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mActive  = 1'b0;
    mHolder  = 4'd0;
    mLast    = 4'(N - 1);
    mHeld    = 0;
    mLock    = '0;
    mTimeout = 1'b0;
  endtask

  // One clock edge of the packet-level arbitration rules.
  task automatic modelStep(input logic [N-1:0] r);
    logic [N-1:0] oldLock;
    logic [3:0]   base;
    logic [3:0]   p;
    logic         hit;
    oldLock  = mLock;
    mTimeout = 1'b0;
    mLock    = mLock & r;
    if (mActive) begin
      if (!r[mHolder]) begin
        mActive = 1'b0;
      end else if (mHeld == TIMEOUT) begin
        mLock[mHolder] = 1'b1;
        mTimeout       = 1'b1;
        mActive        = 1'b0;
      end else begin
        mHeld++;
      end
    end else begin
      hit  = 1'b0;
      base = mLast;
      for (int k = 1; k <= N; k++) begin
        p = base + 4'(k);
        if (!hit && r[p] && !oldLock[p]) begin
          hit     = 1'b1;
          mActive = 1'b1;
          mHolder = p;
          mHeld   = 1;
          mLast   = p;
        end
      end
    end
  endtask

  task automatic checkAll(input logic [N-1:0] r);
    logic [N-1:0] expGrant;
    expGrant = mActive ? (N'(1) << mHolder) : '0;
    checkOutput("grant",       32'(bus.grant),       32'(expGrant));
    checkOutput("grant_valid", 32'(bus.grant_valid), 32'(mActive));
    checkOutput("grant_id",    32'(bus.grant_id),    mActive ? 32'(mHolder) : 32'd0);
    checkOutput("busy",        32'(bus.busy),        32'(r & ~expGrant));
    checkOutput("timeout_err", 32'(bus.timeout_err), 32'(mTimeout));
  endtask

  // Called at a falling edge; drives req, lets one rising edge pass, checks
  // just after it and returns at the next falling edge.
  task automatic applyStimulus(input logic [N-1:0] r);
    bus.req = r;
    @(posedge clock);
    modelStep(r);
    #1;
    checkAll(r);
    @(negedge clock);
  endtask

  // Called at a falling edge; raises reset between clock edges, checks the
  // asynchronous clear, then releases reset on the next falling edge.
  task automatic resetDut(input logic [N-1:0] r);
    bus.req = r;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_grant",   32'(bus.grant),       32'd0);
    checkOutput("rst_valid",   32'(bus.grant_valid), 32'd0);
    checkOutput("rst_id",      32'(bus.grant_id),    32'd0);
    checkOutput("rst_timeout", 32'(bus.timeout_err), 32'd0);
    checkOutput("rst_busy",    32'(bus.busy),        32'(r));
    @(negedge clock);
    reset = 1'b0;
    modelReset();
  endtask

  initial begin
    logic [N-1:0] r;
    int grantCycles;
    int toutCount;
    int orderIdx;
    int gapLen;
    logic seenFirst;
    logic prevValid;

    reset   = 1'b1;
    bus.req = '0;
    modelReset();
    @(negedge clock);

    // Single packet on port 0, five cycles long.
    resetDut(16'h0000);
    grantCycles = 0;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(16'h0001);
      if (bus.grant == 16'h0001) grantCycles++;
    end
    applyStimulus(16'h0000);
    checkOutput("pkt_release_grant", 32'(bus.grant), 32'd0);
    applyStimulus(16'h0000);
    checkOutput("pkt_len", 32'(grantCycles), 32'd5);

    // All ports requesting, three-cycle packets: strict rotation, 1-cycle gaps.
    resetDut(16'h0000);
    orderIdx  = 0;
    gapLen    = 0;
    seenFirst = 1'b0;
    prevValid = 1'b0;
    for (int c = 0; c < 72; c++) begin
      r = '1;
      if (mActive && mHeld == 3) r[mHolder] = 1'b0;
      applyStimulus(r);
      if (bus.grant_valid) begin
        if (!prevValid) begin
          if (orderIdx < 17) checkOutput("rr_order", 32'(bus.grant_id), 32'(orderIdx % 16));
          if (seenFirst) checkOutput("rr_gap", 32'(gapLen), 32'd1);
          seenFirst = 1'b1;
          orderIdx++;
        end
        gapLen = 0;
      end else begin
        gapLen++;
      end
      prevValid = bus.grant_valid;
    end
    checkOutput("rr_packets", 32'(orderIdx >= 17), 32'd1);

    // Wrap-around: after port 14 wins, port 0 beats port 14.
    resetDut(16'h0000);
    applyStimulus(16'h4000);
    applyStimulus(16'h0000);
    applyStimulus(16'h4001);
    checkOutput("wrap_id", 32'(bus.grant_id), 32'd0);

    // Timeout with lockout on port 3.
    resetDut(16'h0000);
    grantCycles = 0;
    toutCount   = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(16'h0008);
      if (bus.grant[3]) grantCycles++;
      if (bus.timeout_err) toutCount++;
    end
    checkOutput("tout_grant_cycles", 32'(grantCycles), 32'd8);
    checkOutput("tout_pulses",       32'(toutCount),   32'd1);
    checkOutput("tout_busy3",        32'(bus.busy[3]), 32'd1);
    applyStimulus(16'h0000);
    applyStimulus(16'h0008);
    checkOutput("relock_regrant", 32'(bus.grant), 32'h0008);

    // Release on the last allowed cycle is a normal release.
    resetDut(16'h0000);
    toutCount = 0;
    for (int c = 0; c < 8; c++) applyStimulus(16'h0008);
    applyStimulus(16'h0000);
    if (bus.timeout_err) toutCount++;
    checkOutput("edge_tout_pulses", 32'(toutCount), 32'd0);
    applyStimulus(16'h0008);
    checkOutput("edge_regrant", 32'(bus.grant), 32'h0008);

    // Reset during a grant of port 7, then port 0 goes first.
    resetDut(16'h0000);
    applyStimulus(16'h0080);
    for (int c = 0; c < 3; c++) applyStimulus(16'h0081);
    checkOutput("pre_rst_grant", 32'(bus.grant), 32'h0080);
    resetDut(16'h0081);
    applyStimulus(16'h0081);
    checkOutput("post_rst_grant", 32'(bus.grant), 32'h0001);

    // Randomized requests: sparse toggling gives packets of varied length,
    // including ones long enough to time out.
    resetDut(16'h0000);
    r = '0;
    for (int c = 0; c < 1500; c++) begin
      r = r ^ N'($urandom & $urandom & $urandom);
      if (c == 750) resetDut(r);
      applyStimulus(r);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
